floor_sensor: RTL and testbench

//  Synthesizable plant model that closes the loop around the elevator controller.

---
 rtl/floor_sensor.sv | 136 +++++++++++++
 tb/tb_floor_sensor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_sensor.sv
`default_nettype none
// ============================================================================
// Module      : floor_sensor
// Description : Elevator plant model. Integrates cab position from the
//               controller direction, models the door-closed sensor and
//               produces pseudo-random one-cycle hall/car button presses.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_sensor #(
    parameter int          TRAVEL_CYCLES     = 8,
    parameter int          DOOR_CLOSE_CYCLES = 5,
    parameter int          PRESS_INTERVAL    = 16,
    parameter logic [15:0] SEED              = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dir,
    input  logic       door,
    input  logic       btn_en,
    output logic [1:0] fs,
    output logic       dc,
    output logic       u1,
    output logic       u2,
    output logic       d2,
    output logic       d3,
    output logic       f1,
    output logic       f2,
    output logic       f3
);

    localparam int          POS_MAX  = 2 * TRAVEL_CYCLES;
    localparam int          PW       = $clog2(POS_MAX + 1);
    localparam int          DW       = $clog2(DOOR_CLOSE_CYCLES + 1);
    localparam int          IW       = (PRESS_INTERVAL > 1) ? $clog2(PRESS_INTERVAL) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    localparam logic [PW-1:0] POS_F1   = '0;
    localparam logic [PW-1:0] POS_F2   = PW'(TRAVEL_CYCLES);
    localparam logic [PW-1:0] POS_F3   = PW'(POS_MAX);
    localparam logic [DW-1:0] DOOR_END = DW'(DOOR_CLOSE_CYCLES - 1);
    localparam logic [IW-1:0] INT_END  = IW'(PRESS_INTERVAL - 1);

    logic [PW-1:0] pos_q, pos_d;
    logic [1:0]    fs_q, fs_d;
    logic          dc_q, dc_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [6:0]    btn_q, btn_d;
    logic          wrap;

    // Cab motion (only with the door fully closed) and floor decode of the next position
    always_comb begin
        pos_d = pos_q;
        if (dc_q) begin
            if (dir == 2'b01 && pos_q != POS_F3) begin
                pos_d = pos_q + PW'(1);
            end else if (dir == 2'b10 && pos_q != POS_F1) begin
                pos_d = pos_q - PW'(1);
            end
        end
        if (pos_d == POS_F1) begin
            fs_d = 2'b01;
        end else if (pos_d == POS_F2) begin
            fs_d = 2'b10;
        end else if (pos_d == POS_F3) begin
            fs_d = 2'b11;
        end else begin
            fs_d = 2'b00;
        end
    end

    // Door sensor: open immediately on command, close after a full uninterrupted countdown
    always_comb begin
        dc_d   = dc_q;
        dcnt_d = dcnt_q;
        if (door) begin
            dc_d   = 1'b0;
            dcnt_d = '0;
        end else if (!dc_q) begin
            if (dcnt_q == DOOR_END) begin
                dc_d   = 1'b1;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    // Button generator: free-running LFSR, interval counter gated by btn_en, one-hot press on wrap
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        wrap   = btn_en && (icnt_q == INT_END);
        icnt_d = icnt_q;
        btn_d  = '0;
        if (btn_en) begin
            icnt_d = wrap ? '0 : icnt_q + IW'(1);
        end
        if (wrap && lfsr_q[2:0] != 3'd7) begin
            btn_d = 7'b000_0001 << lfsr_q[2:0];
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q  <= '0;
            fs_q   <= 2'b01;
            dc_q   <= 1'b1;
            dcnt_q <= '0;
            lfsr_q <= SEED_EFF;
            icnt_q <= '0;
            btn_q  <= '0;
        end else begin
            pos_q  <= pos_d;
            fs_q   <= fs_d;
            dc_q   <= dc_d;
            dcnt_q <= dcnt_d;
            lfsr_q <= lfsr_d;
            icnt_q <= icnt_d;
            btn_q  <= btn_d;
        end
    end

    assign fs = fs_q;
    assign dc = dc_q;
    assign u1 = btn_q[0];
    assign u2 = btn_q[1];
    assign d2 = btn_q[2];
    assign d3 = btn_q[3];
    assign f1 = btn_q[4];
    assign f2 = btn_q[5];
    assign f3 = btn_q[6];

endmodule
`default_nettype wire

// File: tb/tb_floor_sensor.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_sensor
// Description : Self-checking bench for floor_sensor with a behavioural
//               plant/button reference model and directed plus random steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_sensor;

    localparam int          T       = 8;
    localparam int          DCC     = 5;
    localparam int          PI      = 16;
    localparam logic [15:0] SEED_V  = 16'hACE1;
    localparam int          POS_MAX = 2 * T;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       door = 1'b0;
    logic       btn_en = 1'b0;
    logic [1:0] fs;
    logic       dc, u1, u2, d2, d3, f1, f2, f3;
    logic [6:0] btn_vec;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_pos;
    logic        m_dc;
    int          m_edge;
    int          m_last_door;
    int unsigned m_lfsr;
    int          m_en_cycles;
    logic [6:0]  m_btn;
    int          m_press;
    int          dut_press;

    floor_sensor #(
        .TRAVEL_CYCLES(T), .DOOR_CLOSE_CYCLES(DCC), .PRESS_INTERVAL(PI), .SEED(SEED_V)
    ) dut (
        .clk(clk), .rst(rst), .dir(dir), .door(door), .btn_en(btn_en),
        .fs(fs), .dc(dc), .u1(u1), .u2(u2), .d2(d2), .d3(d3),
        .f1(f1), .f2(f2), .f3(f3)
    );

    assign btn_vec = {f3, f2, f1, d3, d2, u2, u1};

    always #5 clk = ~clk;

    function automatic logic [1:0] fs_of(input int p);
        if (p == 0)            return 2'b01;
        else if (p == T)       return 2'b10;
        else if (p == POS_MAX) return 2'b11;
        else                   return 2'b00;
    endfunction

    // Fibonacci LFSR with taps 16,14,13,11 (bits 0,2,3,5 of a right-shifting register)
    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return ((s >> 1) | (b << 15)) & 32'hFFFF;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pos       = 0;
        m_dc        = 1'b1;
        m_edge      = 0;
        m_last_door = -1000000;
        m_lfsr      = SEED_V;
        m_en_cycles = 0;
        m_btn       = '0;
    endtask

    // Advance the model by one edge using current inputs, clock the DUT, compare everything
    task automatic tick();
        logic dc_before;
        int   ch;
        dc_before = m_dc;
        if (dc_before) begin
            if (dir == 2'b01 && m_pos < POS_MAX)  m_pos++;
            else if (dir == 2'b10 && m_pos > 0)   m_pos--;
        end
        m_edge++;
        if (door) m_last_door = m_edge;
        m_dc  = ((m_edge - m_last_door) >= DCC);
        m_btn = '0;
        if (btn_en) begin
            ch = int'(m_lfsr & 7);
            if ((m_en_cycles % PI) == PI - 1 && ch != 7) begin
                m_btn = 7'(1 << ch);
                m_press++;
            end
            m_en_cycles++;
        end
        m_lfsr = lfsr_next(m_lfsr);
        @(posedge clk);
        #1;
        chk("fs",     16'(fs),      16'(fs_of(m_pos)));
        chk("dc",     16'(dc),      16'(m_dc));
        chk("btn",    16'(btn_vec), 16'(m_btn));
        chk("onehot", 16'($countones(btn_vec) <= 1), 16'd1);
        if (btn_vec != 7'd0) dut_press++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m_reset();
        m_press   = 0;
        dut_press = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fs",  16'(fs),      16'h1);
        chk("rst_dc",  16'(dc),      16'h1);
        chk("rst_btn", 16'(btn_vec), 16'h0);
        rst = 1'b1;

        // Upward travel F1 -> F3
        dir = 2'b01;
        tick();
        chk("up_leave_f1", 16'(fs), 16'h0);
        ticks(7);
        chk("up_at_f2", 16'(fs), 16'h2);
        ticks(8);
        chk("up_at_f3", 16'(fs), 16'h3);
        ticks(4);
        chk("up_hold_f3", 16'(fs), 16'h3);

        // Downward travel F3 -> F2, then stop
        dir = 2'b10;
        tick();
        chk("dn_leave_f3", 16'(fs), 16'h0);
        ticks(7);
        chk("dn_at_f2", 16'(fs), 16'h2);
        dir = 2'b00;
        ticks(10);
        chk("stop_f2", 16'(fs), 16'h2);
        dir = 2'b11;
        ticks(3);
        chk("dir11_f2", 16'(fs), 16'h2);

        // Door open 3 cycles, close countdown; no motion with the door open
        dir  = 2'b00;
        door = 1'b1;
        tick();
        chk("door_open", 16'(dc), 16'h0);
        dir = 2'b01;
        ticks(2);
        door = 1'b0;
        for (int i = 0; i < DCC - 1; i++) begin
            tick();
            chk("door_counting", 16'(dc), 16'h0);
            chk("door_nomove", 16'(fs), 16'h2);
        end
        dir = 2'b00;
        tick();
        chk("door_closed", 16'(dc), 16'h1);

        // Door re-asserted mid-countdown aborts it
        door = 1'b1;
        tick();
        door = 1'b0;
        ticks(3);
        chk("abort_mid", 16'(dc), 16'h0);
        door = 1'b1;
        tick();
        chk("abort_reopen", 16'(dc), 16'h0);
        door = 1'b0;
        ticks(DCC - 1);
        chk("abort_full_wait", 16'(dc), 16'h0);
        tick();
        chk("abort_closed", 16'(dc), 16'h1);

        // Random run with the button generator on
        btn_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dir  = 2'($urandom_range(0, 3));
            door = ($urandom_range(0, 15) == 0);
            tick();
        end
        chk("press_seen", 16'(m_press > 0), 16'd1);

        // Random enable gating
        for (int i = 0; i < 512; i++) begin
            dir    = 2'($urandom_range(0, 3));
            door   = ($urandom_range(0, 31) == 0);
            btn_en = ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("press_count", 16'(dut_press), 16'(m_press));

        // Generator disabled: no presses at all
        btn_en    = 1'b0;
        door      = 1'b0;
        dut_press = 0;
        ticks(200);
        chk("disabled_zero", 16'(dut_press), 16'h0);

        // Async reset mid-travel between F1 and F2
        rst = 1'b0;
        #1;
        m_reset();
        rst = 1'b1;
        dir = 2'b01;
        btn_en = 1'b1;
        ticks(4);
        chk("mid_travel", 16'(fs), 16'h0);
        #3;
        rst = 1'b0;
        #1;
        chk("async_fs",  16'(fs),      16'h1);
        chk("async_dc",  16'(dc),      16'h1);
        chk("async_btn", 16'(btn_vec), 16'h0);
        @(posedge clk);
        #1;
        chk("held_fs", 16'(fs), 16'h1);
        m_reset();
        rst = 1'b1;
        tick();
        chk("restart_leave", 16'(fs), 16'h0);
        ticks(T - 1);
        chk("restart_f2", 16'(fs), 16'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
